// File: rtl/sram_bus_arbiter.sv
// Merges the core's inst-SRAM and data-SRAM ports onto one req/ack memory bus.
// Data side wins; one transaction outstanding; sticky error on bus timeout.
module sram_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_for_mem,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic               inst_pend_q, inst_pend_d;
    logic [31:0]        i_addr_q, i_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [31:0]        inst_rdata_q, inst_rdata_d;
    logic [31:0]        data_rdata_q, data_rdata_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_wr_q, bus_wr_d;
    logic [3:0]         bus_wstrb_q, bus_wstrb_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;

    logic in_wait;
    logic timeout;
    logic finish;

    assign in_wait = (state_q == D_WAIT) || (state_q == I_WAIT);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign finish  = bus_ack || timeout;

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d      = state_q;
        inst_pend_d  = inst_pend_q;
        i_addr_d     = i_addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    inst_pend_d = inst_sram_en;
                    i_addr_d    = inst_sram_addr;
                    state_d     = D_WAIT;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = |data_sram_wen;
                    bus_wstrb_d = data_sram_wen;
                    bus_addr_d  = data_sram_addr;
                    bus_wdata_d = data_sram_wdata;
                end else if (inst_sram_en) begin
                    i_addr_d    = inst_sram_addr;
                    state_d     = I_WAIT;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = 4'b0;
                    bus_addr_d  = inst_sram_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            D_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    cnt_d = '0;
                    // An ack on the abort cycle wins over the timeout.
                    if (!bus_ack) begin
                        err_d        = 1'b1;
                        data_rdata_d = 32'h0;
                    end else if (!bus_wr_q) begin
                        data_rdata_d = bus_rdata;
                    end
                    if (inst_pend_q) begin
                        state_d     = I_WAIT;
                        bus_wr_d    = 1'b0;
                        bus_wstrb_d = 4'b0;
                        bus_addr_d  = i_addr_q;
                        bus_wdata_d = 32'h0;
                    end else begin
                        state_d   = DONE;
                        bus_req_d = 1'b0;
                    end
                end
            end
            I_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    cnt_d        = '0;
                    inst_rdata_d = bus_ack ? bus_rdata : 32'h0;
                    if (!bus_ack) err_d = 1'b1;
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                // DONE: the still-held core request was just served, so ignore it.
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            inst_pend_q  <= 1'b0;
            i_addr_q     <= 32'h0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= 4'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            inst_pend_q  <= inst_pend_d;
            i_addr_q     <= i_addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign stallreq_for_mem = ((state_q == IDLE) && (inst_sram_en || data_sram_en)) || in_wait;
    assign inst_sram_rdata  = inst_rdata_q;
    assign data_sram_rdata  = data_rdata_q;
    assign bus_req          = bus_req_q;
    assign bus_wr           = bus_wr_q;
    assign bus_wstrb        = bus_wstrb_q;
    assign bus_addr         = bus_addr_q;
    assign bus_wdata        = bus_wdata_q;
    assign bus_err          = err_q;

endmodule
